// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA 640x480@60 sync/timing generator; optional colour-bar test pattern behind VGA_TEST_PATTERN_EN
module vga_sync_gen #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [11:0] rgb
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       hs_active;
  logic       vs_active;
  logic       visible;

  // Combinational decode of the current counter position
  always_comb begin
    h_wrap    = (h_cnt == H_LAST);
    hs_active = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    vs_active = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  end

  // Pixel and line counters; the line counter advances only on the pixel wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Registered outputs: one clock behind the counters they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_active ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_active ? VSYNC_POL : ~VSYNC_POL;
      video_on    <= visible;
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      line_start  <= (h_cnt == 10'd0);
      frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int         BAR_W    = H_VISIBLE / 8;
  localparam logic [9:0] BAR_LAST = 10'(BAR_W - 1);

  logic [9:0]  bar_px;
  logic [2:0]  bar_idx;
  logic [11:0] bar_colour;

  // Bar position tracks h_cnt and restarts whenever h_cnt returns to 0
  always_ff @(posedge clk) begin
    if (rst || h_wrap) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (bar_px == BAR_LAST) begin
      bar_px  <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_px  <= bar_px + 10'd1;
    end
  end

  // Bar colour lookup, left to right
  always_comb begin
    bar_colour = 12'h000;
    case (bar_idx)
      3'd0: bar_colour = 12'hFFF;
      3'd1: bar_colour = 12'hFF0;
      3'd2: bar_colour = 12'h0FF;
      3'd3: bar_colour = 12'h0F0;
      3'd4: bar_colour = 12'hF0F;
      3'd5: bar_colour = 12'hF00;
      3'd6: bar_colour = 12'h00F;
      default: bar_colour = 12'h000;
    endcase
  end

  // Colour output, blanked outside the visible area, aligned with video_on
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb <= 12'h000;
    end else begin
      rgb <= visible ? bar_colour : 12'h000;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen (full-size instance plus a shrunken-timing instance)
module tb_vga_sync_gen;

  localparam int BH_V = 40, BH_F = 4, BH_S = 8, BH_B = 4;
  localparam int BV_V = 20, BV_F = 3, BV_S = 2, BV_B = 5;
  localparam int B_HT = BH_V + BH_F + BH_S + BH_B;
  localparam int B_VT = BV_V + BV_F + BV_S + BV_B;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        vo;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        ls;
    logic        fs;
    logic [11:0] rgb;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } pair_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       hsync_a, vsync_a, video_on_a, line_start_a, frame_start_a;
  logic       hsync_b, vsync_b, video_on_b, line_start_b, frame_start_b;
  logic [9:0] pixel_x_a, pixel_y_a, pixel_x_b, pixel_y_b;
`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] rgb_a, rgb_b;
`endif

  vga_sync_gen u_a (
    .clk(clk), .rst(rst_a), .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
    .pixel_x(pixel_x_a), .pixel_y(pixel_y_a), .line_start(line_start_a), .frame_start(frame_start_a)
`ifdef VGA_TEST_PATTERN_EN
    , .rgb(rgb_a)
`endif
  );

  vga_sync_gen #(
    .H_VISIBLE(BH_V), .H_FRONT(BH_F), .H_SYNC(BH_S), .H_BACK(BH_B),
    .V_VISIBLE(BV_V), .V_FRONT(BV_F), .V_SYNC(BV_S), .V_BACK(BV_B)
  ) u_b (
    .clk(clk), .rst(rst_b), .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
    .pixel_x(pixel_x_b), .pixel_y(pixel_y_b), .line_start(line_start_b), .frame_start(frame_start_b)
`ifdef VGA_TEST_PATTERN_EN
    , .rgb(rgb_b)
`endif
  );

  pair_t sb_q[$];
  pair_t got, exp_p;
  int    tests = 0;
  int    fails = 0;
  int    ah = 0, av = 0, bh = 0, bv = 0;

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  function automatic obs_t decode(int h, int v, int hv, int hf, int hs, int vv, int vf, int vs);
    obs_t o;
    logic [11:0] bars [8];
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    o.hs  = !((h >= hv + hf) && (h <= hv + hf + hs - 1));
    o.vs  = !((v >= vv + vf) && (v <= vv + vf + vs - 1));
    o.vo  = (h < hv) && (v < vv);
    o.px  = 10'(h);
    o.py  = 10'(v);
    o.ls  = (h == 0);
    o.fs  = (h == 0) && (v == 0);
`ifdef VGA_TEST_PATTERN_EN
    o.rgb = o.vo ? bars[h / (hv / 8)] : 12'h000;
`else
    o.rgb = 12'h000;
`endif
    return o;
  endfunction

  task automatic advance(inout int h, inout int v, input int ht, input int vt);
    if (h == ht - 1) begin
      h = 0;
      v = (v == vt - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
  endtask

  function automatic pair_t sample();
    pair_t p;
    p.a.hs = hsync_a; p.a.vs = vsync_a; p.a.vo = video_on_a; p.a.px = pixel_x_a;
    p.a.py = pixel_y_a; p.a.ls = line_start_a; p.a.fs = frame_start_a;
    p.b.hs = hsync_b; p.b.vs = vsync_b; p.b.vo = video_on_b; p.b.px = pixel_x_b;
    p.b.py = pixel_y_b; p.b.ls = line_start_b; p.b.fs = frame_start_b;
`ifdef VGA_TEST_PATTERN_EN
    p.a.rgb = rgb_a;
    p.b.rgb = rgb_b;
`else
    p.a.rgb = 12'h000;
    p.b.rgb = 12'h000;
`endif
    return p;
  endfunction

  // Push the expected outputs for the coming edge, clock once, then sample
  task automatic tick();
    pair_t e;
    if (rst_a) begin e.a = reset_obs(); ah = 0; av = 0; end
    else begin e.a = decode(ah, av, 640, 16, 96, 480, 10, 2); advance(ah, av, 800, 525); end
    if (rst_b) begin e.b = reset_obs(); bh = 0; bv = 0; end
    else begin e.b = decode(bh, bv, BH_V, BH_F, BH_S, BV_V, BV_F, BV_S); advance(bh, bv, B_HT, B_VT); end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sample();
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_p = sb_q.pop_front(); tests++;
      if (got !== exp_p) begin fails++; $display("FAIL reset_sb: got a=%h b=%h expected a=%h b=%h", got.a, got.b, exp_p.a, exp_p.b); end
    end
    tests++;
    if ({hsync_a, vsync_a, video_on_a, pixel_x_a, pixel_y_a, line_start_a, frame_start_a} !== {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_vals: got hs=%b vs=%b vo=%b x=%0d y=%0d ls=%b fs=%b expected 1 1 0 0 0 0 0",
                        hsync_a, vsync_a, video_on_a, pixel_x_a, pixel_y_a, line_start_a, frame_start_a);
    end
  endtask

  task automatic test_release();
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();
    exp_p = sb_q.pop_front(); tests++;
    if (got !== exp_p) begin fails++; $display("FAIL release_sb: got a=%h b=%h expected a=%h b=%h", got.a, got.b, exp_p.a, exp_p.b); end
    tests++;
    if ({frame_start_a, line_start_a, video_on_a} !== 3'b111) begin
      fails++; $display("FAIL release_strobes: got fs/ls/vo=%b%b%b expected 111", frame_start_a, line_start_a, video_on_a);
    end
  endtask

  task automatic test_line_timing();
    int vo_cnt = 0, hs_low = 0, hs_bad = 0, ls_cnt = 0, last_ls = -1;
    for (int c = 0; c < 2400; c++) begin
      tick();
      exp_p = sb_q.pop_front(); tests++;
      if (got !== exp_p) begin fails++; $display("FAIL line_sb: got a=%h b=%h expected a=%h b=%h", got.a, got.b, exp_p.a, exp_p.b); end
      if (got.a.vo) vo_cnt++;
      if (!got.a.hs) begin
        hs_low++;
        if (got.a.px < 10'd656 || got.a.px > 10'd751) hs_bad++;
      end
      if (got.a.ls) begin
        ls_cnt++;
        if (last_ls >= 0) begin
          tests++;
          if (c - last_ls != 800) begin fails++; $display("FAIL line_period: got %0d expected 800", c - last_ls); end
        end
        last_ls = c;
      end
    end
    tests++; if (vo_cnt != 1920) begin fails++; $display("FAIL video_on_count: got %0d expected 1920", vo_cnt); end
    tests++; if (hs_low != 288) begin fails++; $display("FAIL hsync_low_count: got %0d expected 288", hs_low); end
    tests++; if (hs_bad != 0) begin fails++; $display("FAIL hsync_window: got %0d stray cycles expected 0", hs_bad); end
    tests++; if (ls_cnt != 3) begin fails++; $display("FAIL line_start_count: got %0d expected 3", ls_cnt); end
  endtask

  task automatic test_frame_timing();
    int fs_cnt = 0, vs_low = 0, last_fs = -1;
    logic prev_vs = 1'b1;
    for (int c = 0; c < 3 * B_HT * B_VT; c++) begin
      tick();
      exp_p = sb_q.pop_front(); tests++;
      if (got !== exp_p) begin fails++; $display("FAIL frame_sb: got a=%h b=%h expected a=%h b=%h", got.a, got.b, exp_p.a, exp_p.b); end
      if (!got.b.vs) vs_low++;
      if (prev_vs && !got.b.vs) begin
        tests++;
        if (got.b.py !== 10'd23 || got.b.px !== 10'd0) begin
          fails++; $display("FAIL vsync_start: got x=%0d y=%0d expected x=0 y=23", got.b.px, got.b.py);
        end
      end
      prev_vs = got.b.vs;
      if (got.b.fs) begin
        fs_cnt++;
        if (last_fs >= 0) begin
          tests++;
          if (c - last_fs != B_HT * B_VT) begin fails++; $display("FAIL frame_period: got %0d expected %0d", c - last_fs, B_HT * B_VT); end
        end
        last_fs = c;
      end
    end
    tests++; if (fs_cnt != 3) begin fails++; $display("FAIL frame_start_count: got %0d expected 3", fs_cnt); end
    tests++; if (vs_low != 3 * BV_S * B_HT) begin fails++; $display("FAIL vsync_low_count: got %0d expected %0d", vs_low, 3 * BV_S * B_HT); end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (!(got.b.py == 10'd10 && got.b.px == 10'd20) && guard < 2000) begin
      tick(); guard++;
      exp_p = sb_q.pop_front(); tests++;
      if (got !== exp_p) begin fails++; $display("FAIL midrst_sb: got a=%h b=%h expected a=%h b=%h", got.a, got.b, exp_p.a, exp_p.b); end
    end
    tests++; if (guard >= 2000) begin fails++; $display("FAIL midrst_b_wait: got timeout expected x=20 y=10"); end
    rst_b = 1'b1;
    tick();
    exp_p = sb_q.pop_front(); tests++;
    if (got !== exp_p) begin fails++; $display("FAIL midrst_b_sb: got b=%h expected b=%h", got.b, exp_p.b); end
    tests++;
    if (got.b.px !== 10'd0 || got.b.py !== 10'd0 || got.b.vo !== 1'b0 || got.b.hs !== 1'b1 || got.b.vs !== 1'b1) begin
      fails++; $display("FAIL midrst_b_vals: got x=%0d y=%0d vo=%b hs=%b vs=%b expected 0 0 0 1 1", got.b.px, got.b.py, got.b.vo, got.b.hs, got.b.vs);
    end
    rst_b = 1'b0;
    guard = 0;
    while (!(got.a.px == 10'd300 && got.a.py != 10'd0) && guard < 2000) begin
      tick(); guard++;
      exp_p = sb_q.pop_front(); tests++;
      if (got !== exp_p) begin fails++; $display("FAIL midrst_sb: got a=%h b=%h expected a=%h b=%h", got.a, got.b, exp_p.a, exp_p.b); end
    end
    tests++; if (guard >= 2000) begin fails++; $display("FAIL midrst_a_wait: got timeout expected x=300"); end
    rst_a = 1'b1;
    tick();
    exp_p = sb_q.pop_front(); tests++;
    if (got !== exp_p) begin fails++; $display("FAIL midrst_a_sb: got a=%h expected a=%h", got.a, exp_p.a); end
    tests++;
    if (got.a !== reset_obs()) begin fails++; $display("FAIL midrst_a_vals: got a=%h expected a=%h", got.a, reset_obs()); end
    rst_a = 1'b0;
    tick();
    exp_p = sb_q.pop_front(); tests++;
    if (got !== exp_p) begin fails++; $display("FAIL restart_sb: got a=%h b=%h expected a=%h b=%h", got.a, got.b, exp_p.a, exp_p.b); end
    tests++;
    if (got.a.px !== 10'd0 || got.a.py !== 10'd0 || got.a.fs !== 1'b1 || got.a.ls !== 1'b1) begin
      fails++; $display("FAIL restart_origin: got x=%0d y=%0d fs=%b ls=%b expected 0 0 1 1", got.a.px, got.a.py, got.a.fs, got.a.ls);
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    logic [11:0] line0 [800];
    for (int c = 0; c < 1599; c++) begin
      tick();
      exp_p = sb_q.pop_front(); tests++;
      if (got !== exp_p) begin fails++; $display("FAIL pattern_sb: got a=%h b=%h expected a=%h b=%h", got.a, got.b, exp_p.a, exp_p.b); end
      if (got.a.py == 10'd0) line0[got.a.px] = got.a.rgb;
      if (got.a.py == 10'd1) begin
        if (got.a.px == 10'd0) begin tests++; if (got.a.rgb !== 12'hFFF) begin fails++; $display("FAIL rgb_x0: got %h expected FFF", got.a.rgb); end end
        if (got.a.px == 10'd80) begin tests++; if (got.a.rgb !== 12'hFF0) begin fails++; $display("FAIL rgb_x80: got %h expected FF0", got.a.rgb); end end
        if (got.a.px >= 10'd560 && got.a.px <= 10'd639) begin tests++; if (got.a.rgb !== 12'h000) begin fails++; $display("FAIL rgb_bar7: got %h at x=%0d expected 000", got.a.rgb, got.a.px); end end
        if (got.a.px == 10'd700) begin tests++; if (got.a.rgb !== 12'h000) begin fails++; $display("FAIL rgb_blank: got %h expected 000", got.a.rgb); end end
        if (got.a.px != 10'd0) begin tests++; if (got.a.rgb !== line0[got.a.px]) begin fails++; $display("FAIL rgb_repeat: got %h at x=%0d expected %h", got.a.rgb, got.a.px, line0[got.a.px]); end end
      end
    end
  endtask
`endif

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    got   = '0;
    test_reset();
    test_release();
    test_line_timing();
    test_frame_timing();
    test_mid_reset();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
